// File: rtl/sdram_burst_writer_if.sv
// Stream-in and burst-write handshake bundle for sdram_burst_writer.
// slave = the burst writer's view, master = producer/controller side.
interface sdram_burst_writer_if #(
    parameter int DQ_WIDTH    = 16,
    parameter int ADDR_WIDTH  = 24,
    parameter int BURST_WIDTH = 9,
    parameter int LVL_WIDTH   = 9
);
    logic [DQ_WIDTH-1:0]    in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   frame_start;
    logic                   flush;
    logic                   wr_req;
    logic [BURST_WIDTH-1:0] wr_len;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [DQ_WIDTH-1:0]    wr_data;
    logic                   wr_valid;
    logic                   wr_finish;
    logic [LVL_WIDTH-1:0]   fifo_level;
    logic                   busy;

    modport slave (
        input  in_data, in_valid, frame_start, flush, wr_valid, wr_finish,
        output in_ready, wr_req, wr_len, wr_addr, wr_data, fifo_level, busy
    );

    modport master (
        output in_data, in_valid, frame_start, flush, wr_valid, wr_finish,
        input  in_ready, wr_req, wr_len, wr_addr, wr_data, fifo_level, busy
    );
endinterface

// File: rtl/sdram_burst_writer.sv
// Buffers a word stream and issues fixed-length write bursts into a circular frame region.
// Latency: wr_data is registered, one clock after each accepted wr_valid.
// Backpressure: in_ready drops only when the FIFO is full; no word is ever dropped.
module sdram_burst_writer #(
    parameter int DQ_WIDTH    = 16,
    parameter int ADDR_WIDTH  = 24,
    parameter int BURST_WIDTH = 9,
    parameter int BURST_LEN   = 64,
    parameter int FIFO_DEPTH  = 256,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 307200
) (
    input  logic                clk,
    input  logic                rst,
    sdram_burst_writer_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [LW-1:0]          DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]          BLEN_L  = LW'(BURST_LEN);
    localparam logic [ADDR_WIDTH:0]    BLEN_A  = (ADDR_WIDTH+1)'(BURST_LEN);
    localparam logic [ADDR_WIDTH:0]    END_A   = (ADDR_WIDTH+1)'(BASE_ADDR + FRAME_WORDS);
    localparam logic [ADDR_WIDTH-1:0]  BASE_A  = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DQ_WIDTH-1:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [LW-1:0]          r_level;
    logic [BURST_WIDTH-1:0] r_len;
    logic [BURST_WIDTH-1:0] r_pop_cnt;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DQ_WIDTH-1:0]    r_data;
    logic                   r_flush_pend;
    logic                   r_fs_pend;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_launch;
    logic                   w_leave;
    logic [ADDR_WIDTH-1:0]  w_start_addr;
    logic [ADDR_WIDTH:0]    w_rem;
    logic [ADDR_WIDTH:0]    w_lvl_a;
    logic [ADDR_WIDTH:0]    w_len_a;
    logic [BURST_WIDTH-1:0] w_len;
    logic [ADDR_WIDTH:0]    w_sum;
    logic [ADDR_WIDTH-1:0]  w_next_addr;

    assign w_push = bus.in_valid && (r_level < DEPTH_L);
    // Pops are capped at the burst length and never touch an empty FIFO.
    assign w_pop  = (r_state != S_IDLE) && bus.wr_valid &&
                    (r_pop_cnt < r_len) && (r_level != '0);

    // A pending frame restart is folded into the address the next burst is sized against.
    assign w_start_addr = r_fs_pend ? BASE_A : r_addr;
    assign w_rem        = END_A - {1'b0, w_start_addr};
    assign w_lvl_a      = (ADDR_WIDTH+1)'(r_level);

    always_comb begin
        w_len_a = BLEN_A;
        if (w_rem < w_len_a) begin
            w_len_a = w_rem;
        end
        if (w_lvl_a < w_len_a) begin
            w_len_a = w_lvl_a;
        end
    end
    assign w_len = w_len_a[BURST_WIDTH-1:0];

    assign w_sum       = {1'b0, r_addr} + (ADDR_WIDTH+1)'(r_len);
    assign w_next_addr = (r_fs_pend || bus.frame_start || (w_sum >= END_A)) ?
                         BASE_A : w_sum[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_leave     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_level >= BLEN_L) || (r_flush_pend && (r_level != '0))) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.wr_valid) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.wr_finish) begin
                    w_leave     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_len        <= '0;
            r_pop_cnt    <= '0;
            r_addr       <= BASE_A;
            r_data       <= '0;
            r_flush_pend <= 1'b0;
            r_fs_pend    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PW'(1);
                r_data    <= r_mem[r_rd_ptr];
                r_pop_cnt <= r_pop_cnt + BURST_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            if (w_launch) begin
                r_len     <= w_len;
                r_pop_cnt <= '0;
            end

            if (bus.flush) begin
                r_flush_pend <= 1'b1;
            end else if (r_level == '0) begin
                r_flush_pend <= 1'b0;
            end

            // Restart in IDLE wins; otherwise a restart seen mid-burst lands on burst exit.
            if ((r_state == S_IDLE) && r_fs_pend) begin
                r_addr    <= BASE_A;
                r_fs_pend <= bus.frame_start;
            end else if (w_leave) begin
                r_addr    <= w_next_addr;
                r_fs_pend <= 1'b0;
            end else if (bus.frame_start) begin
                r_fs_pend <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = (r_level < DEPTH_L);
    assign bus.wr_req     = (r_state == S_REQ);
    assign bus.wr_len     = r_len;
    assign bus.wr_addr    = r_addr;
    assign bus.wr_data    = r_data;
    assign bus.fifo_level = r_level;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_sdram_burst_writer.sv
// Directed-sequence bench with random data and wr_valid spacing, checked against a
// queue-based model of the FIFO contents and the circular frame address.
module tb_sdram_burst_writer;
    localparam int DQW   = 16;
    localparam int AW    = 24;
    localparam int BW    = 9;
    localparam int BL    = 64;
    localparam int DEPTH = 256;
    localparam int LVLW  = 9;
    localparam int BASE  = 0;
    localparam int FRAME = 160;
    localparam int ENDA  = BASE + FRAME;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdram_burst_writer_if #(
        .DQ_WIDTH(DQW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW), .LVL_WIDTH(LVLW)
    ) bus ();

    sdram_burst_writer #(
        .DQ_WIDTH(DQW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW), .BURST_LEN(BL),
        .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .FRAME_WORDS(FRAME)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DQW-1:0] q[$];
    int             m_addr;
    bit             m_fs_pend;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input int n, input int budget, output int sent);
        int cyc;
        logic [DQW-1:0] d;
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.in_ready === 1'b1) begin
                d = DQW'($urandom);
                bus.in_valid = 1'b1;
                bus.in_data  = d;
                q.push_back(d);
                sent++;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic push_exact(input int n);
        int sent;
        push_words(n, 4 * n + 20, sent);
        chk("push_count", 64'(sent), 64'(n));
    endtask

    task automatic wait_req(output bit ok);
        int n;
        n = 0;
        while (bus.wr_req !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.wr_req === 1'b1);
        if (!ok) chk("wr_req_rise", 64'(bus.wr_req), 64'(1));
    endtask

    // Serve one burst: length/address from the model, exp_len+extra wr_valid pulses.
    task automatic do_burst(input int extra, input bit fs_during);
        int exp_len;
        int exp_next;
        bit ok;
        logic [DQW-1:0] last;
        logic [DQW-1:0] exp_d;
        if (m_fs_pend) begin
            m_addr    = BASE;
            m_fs_pend = 1'b0;
        end
        exp_len = BL;
        if (ENDA - m_addr < exp_len) exp_len = ENDA - m_addr;
        if (q.size() < exp_len) exp_len = q.size();
        last = '0;
        wait_req(ok);
        if (!ok) return;
        chk("wr_len", 64'(bus.wr_len), 64'(exp_len));
        chk("wr_addr", 64'(bus.wr_addr), 64'(m_addr));
        chk("busy_req", 64'(bus.busy), 64'(1));
        for (int i = 0; i < exp_len + extra; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus.wr_valid = 1'b1;
            @(negedge clk);
            bus.wr_valid = 1'b0;
            if (i < exp_len) begin
                exp_d = q.pop_front();
                last  = exp_d;
            end else begin
                exp_d = last;
            end
            chk($sformatf("wr_data[%0d]", i), 64'(bus.wr_data), 64'(exp_d));
            if (i == 0) chk("wr_req_drop", 64'(bus.wr_req), 64'(0));
            if (fs_during && i == 1) begin
                bus.frame_start = 1'b1;
                @(negedge clk);
                bus.frame_start = 1'b0;
                m_fs_pend = 1'b1;
            end
        end
        bus.wr_finish = 1'b1;
        @(negedge clk);
        bus.wr_finish = 1'b0;
        exp_next = m_addr + exp_len;
        if (exp_next >= ENDA) exp_next = BASE;
        if (m_fs_pend) begin
            exp_next  = BASE;
            m_fs_pend = 1'b0;
        end
        m_addr = exp_next;
        chk("busy_after", 64'(bus.busy), 64'(0));
        chk("addr_after", 64'(bus.wr_addr), 64'(m_addr));
    endtask

    initial begin
        int sent;
        int guard;
        bit ok;
        rst             = 1'b1;
        bus.in_data     = '0;
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
        bus.flush       = 1'b0;
        bus.wr_valid    = 1'b0;
        bus.wr_finish   = 1'b0;
        m_addr          = BASE;
        m_fs_pend       = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_wr_req", 64'(bus.wr_req), 64'(0));
        chk("rst_wr_len", 64'(bus.wr_len), 64'(0));
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'(BASE));
        chk("rst_wr_data", 64'(bus.wr_data), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_level", 64'(bus.fifo_level), 64'(0));

        // One full burst
        push_exact(BL);
        do_burst(0, 1'b0);
        chk("a_level", 64'(bus.fifo_level), 64'(q.size()));

        // Stalled controller: FIFO fills, in_ready drops, nothing lost
        push_words(300, 300, sent);
        chk("b_accepted", 64'(sent), 64'(DEPTH));
        chk("b_in_ready", 64'(bus.in_ready), 64'(0));
        chk("b_level_full", 64'(bus.fifo_level), 64'(DEPTH));
        do_burst(0, 1'b0);
        push_exact(300 - sent);
        guard = 0;
        while (q.size() >= BL && guard < 20) begin
            do_burst(0, 1'b0);
            guard++;
        end
        chk("b_level", 64'(bus.fifo_level), 64'(q.size()));

        // Flush a short remainder
        push_exact($urandom_range(1, 63 - q.size()));
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        do_burst(0, 1'b0);
        chk("f_level", 64'(bus.fifo_level), 64'(0));
        push_exact(5);
        repeat (10) @(negedge clk);
        chk("f_cleared_req", 64'(bus.wr_req), 64'(0));
        chk("f_cleared_busy", 64'(bus.busy), 64'(0));

        // frame_start while idle, then during DATA of the burst at 64
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        repeat (3) @(negedge clk);
        m_addr    = BASE;
        m_fs_pend = 1'b0;
        chk("fs_idle_addr", 64'(bus.wr_addr), 64'(m_addr));
        push_exact(2 * BL - q.size());
        do_burst(0, 1'b0);
        do_burst(0, 1'b1);
        chk("fs_level", 64'(bus.fifo_level), 64'(q.size()));

        // Surplus wr_valid pulses must not pop
        push_exact(100);
        do_burst(6, 1'b0);
        chk("x_level", 64'(bus.fifo_level), 64'(100 - BL));
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        do_burst(0, 1'b0);
        chk("x_level_drained", 64'(bus.fifo_level), 64'(0));

        // Reset in the middle of a burst
        push_exact(BL);
        wait_req(ok);
        repeat (10) begin
            bus.wr_valid = 1'b1;
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_addr    = BASE;
        m_fs_pend = 1'b0;
        chk("r_wr_req", 64'(bus.wr_req), 64'(0));
        chk("r_level", 64'(bus.fifo_level), 64'(0));
        chk("r_wr_addr", 64'(bus.wr_addr), 64'(BASE));
        chk("r_busy", 64'(bus.busy), 64'(0));

        // Normal operation after reset
        push_exact(BL);
        do_burst(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_burst_writer.md
Name: sdram_burst_writer

Overview:
- Upstream feeder for the SDRAM controller's burst-write port.
- Accepts a word stream with a valid/ready handshake and buffers it in an internal FIFO.
- Issues fixed-length write bursts (req/len/addr/data, with valid and finish returned by the controller) to successive addresses in a circular frame region.
- Sits between the pixel/data producer and the SDRAM controller.

Parameters:
DQ_WIDTH, 16, data word width (matches SDRAM dq)
ADDR_WIDTH, 24, word address width (ba+row+col)
BURST_WIDTH, 9, width of burst length field
BURST_LEN, 64, words per normal burst (1..2^BURST_WIDTH-1)
FIFO_DEPTH, 256, input FIFO entries; power of 2, >= 2*BURST_LEN
BASE_ADDR, 0, first word address of the frame region
FRAME_WORDS, 307200, words in the frame region; the address wraps after this

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_data  input  DQ_WIDTH  stream word
in_valid  input  1  stream word valid
in_ready  output  1  FIFO can accept; a word transfers when in_valid & in_ready
frame_start  input  1  pulse: next burst restarts at BASE_ADDR
flush  input  1  pulse: write the remaining FIFO words even if fewer than BURST_LEN
wr_req  output  1  burst write request to controller
wr_len  output  BURST_WIDTH  burst length, stable while wr_req high
wr_addr  output  ADDR_WIDTH  burst start address, stable while wr_req high
wr_data  output  DQ_WIDTH  write data
wr_valid  input  1  controller data request, 1 clock ahead of data sampling
wr_finish  input  1  controller pulse: burst complete
fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) clears everything:
  - FIFO empty; state IDLE.
  - wr_req=0, wr_len=0, wr_addr=BASE_ADDR, wr_data=0.
  - in_ready=1, busy=0, fifo_level=0; pending flush and frame_start flags cleared.
  - Reset mid-burst abandons the burst; wr_req drops on the next cycle.
- FIFO:
  - in_ready = (fifo_level < FIFO_DEPTH).
  - A push and a pop in the same cycle leave the level unchanged.
  - A push when full is impossible by construction.
- State machine, states IDLE, REQ, DATA:
  - IDLE -> REQ when fifo_level >= BURST_LEN. wr_len = min(BURST_LEN, words remaining to frame end).
  - IDLE -> REQ when flush is pending and fifo_level > 0. wr_len = min(fifo_level, BURST_LEN, remaining); the flush flag clears once the FIFO drains to 0.
  - wr_len and wr_addr are registered on entry to REQ and held until return to IDLE.
  - REQ: wr_req=1. Go to DATA on the first cycle wr_valid=1.
  - DATA: wr_req=0. Return to IDLE on wr_finish=1.
  - The address update happens on leaving DATA: wr_addr += wr_len; if the result >= BASE_ADDR+FRAME_WORDS, wr_addr = BASE_ADDR.
- Data timing:
  - In REQ or DATA, each cycle with wr_valid=1 pops one FIFO word.
  - wr_data is registered and updates the cycle after the pop, giving exactly 1 clock latency from wr_valid.
  - Pops per burst are capped at wr_len. Extra wr_valid cycles do not pop and leave wr_data unchanged.
  - A pop never occurs on an empty FIFO.
- frame_start:
  - Sets a pending flag.
  - Applied in IDLE before evaluating the next burst: wr_addr=BASE_ADDR, flag cleared.
  - A pulse during REQ/DATA takes effect after the current burst, overriding the wrap computation.
- flush and frame_start in the same cycle: both are latched. The address reset is applied first, then the flush burst.
- A wr_finish that arrives in IDLE or REQ is ignored.
- The FIFO does not drop data. Backpressure is via in_ready only.

Test Plan:
- Reset, then push 64 words 0x0000..0x003F with BURST_LEN=64 -> wr_req rises with wr_len=64, wr_addr=0. The controller model pulses wr_valid 64 cycles; wr_data shows 0x0000..0x003F, each 1 cycle after its wr_valid. After wr_finish: wr_addr=64, fifo_level=0, busy=0.
- Push 300 words with the controller stalled (no wr_valid) -> in_ready falls when fifo_level=256 and no words are lost. After release, 4 bursts of 64 go to addresses 0, 64, 128, 192, with data in order.
- FRAME_WORDS=160, 3 full bursts -> addresses 0, 64, then 128 with wr_len=32. The next burst goes to 0 and carries the remaining 32 words in order.
- Push 10 words, pulse flush -> one burst with wr_len=10 at the current address; wr_data shows the 10 words; flush clears and busy=0.
- frame_start pulsed during DATA of the burst at address 64 -> the next burst goes to address 0, not 128.
- Controller model issues 70 wr_valid for wr_len=64 -> exactly 64 pops and fifo_level drops by 64. Separately, asserting rst mid-DATA gives wr_req=0, fifo_level=0, wr_addr=BASE_ADDR on the next cycle.
